bus_fabric: RTL and testbench
=============================

// Module: bus_fabric
// PURPOSE
//  Parametrised single-master, N-slave memory-mapped bus fabric between cpu and peripherals.
//  Decodes the address against a per-slave base/mask table and forwards writes as posted transactions.
//  Tracks one outstanding read and returns registered read data from the slave latched at request time.
//  Reports an error on unmapped accesses, and optionally on read timeout.
// PARAMETERS
//  NSLAVES  4                      number of slave ports (1..8)
//  ADDR_W   16                     address width
//  DATA_W   32                     data width; DATA_W/8 mask bits
//  SLV_BASE {5000,4000,8000,0000}  packed NSLAVES*ADDR_W, slave i at [i*ADDR_W +: ADDR_W]
//  SLV_MASK {F000,F000,8000,C000}  packed; slave i hit = (m_addr & MASK_i) == BASE_i
//  TIMEOUT  16                     read wait limit in cycles (BUS_TIMEOUT_EN only); 2..255
//  ERR_DATA 32'hDEADBEEF           m_rd_data returned with an error response
// PORTS
//  clk         in   1              clock, rising edge
//  rst_n       in   1              synchronous reset, active low
//  m_addr      in   ADDR_W         master address
//  m_rd_en     in   1              read request, one-cycle pulse
//  m_wr_en     in   1              write request, one-cycle pulse
//  m_wr_data   in   DATA_W         write data
//  m_wr_mask   in   DATA_W/8       byte-enable mask
//  m_rd_data   out  DATA_W         registered read data
//  m_rd_valid  out  1              read response strobe, one cycle
//  m_err       out  1              error strobe, one cycle
//  m_busy      out  1              read outstanding; master must not issue requests
//  s_addr      out  ADDR_W         m_addr, passed through
//  s_wr_data   out  DATA_W         m_wr_data, passed through
//  s_wr_mask   out  DATA_W/8       m_wr_mask, passed through
//  s_rd_en     out  NSLAVES        per-slave read enable
//  s_wr_en     out  NSLAVES        per-slave write enable
//  s_rd_data   in   NSLAVES*DATA_W per-slave read data, packed
//  s_rd_valid  in   NSLAVES        per-slave read valid
// BEHAVIOUR
//  Reset: rst_n=0 at clk edge sets state=IDLE, sel=0, cnt=0, m_rd_valid=0, m_err=0, m_rd_data=0.
//   m_busy=0 during and after reset. A read in flight is abandoned and no response is issued.
//  Decode is combinational. The lowest-index hit wins; no hit means unmapped.
//  FSM IDLE:
//   - wr_en only, hit i: s_wr_en[i]=1 in the same cycle (posted); fabric stays in IDLE.
//   - wr_en only, unmapped: write dropped; m_err=1 on the next cycle.
//   - rd_en only, hit i: s_rd_en[i]=1 in the same cycle; sel<=i, cnt<=0, go to RD_WAIT.
//   - rd_en only, unmapped: next cycle m_rd_valid=1, m_err=1, m_rd_data=ERR_DATA; stay in IDLE.
//   - rd_en and wr_en together: nothing is forwarded; m_err=1 on the next cycle.
//  FSM RD_WAIT:
//   - m_busy=1; s_rd_en and s_wr_en are all 0; new master requests are ignored.
//   - s_rd_valid[sel]=1: next cycle m_rd_valid=1, m_rd_data=s_rd_data[sel], m_err=0; go to IDLE.
//   - s_rd_valid from a slave other than sel is ignored.
//  Read latency: m_rd_valid follows s_rd_valid[sel] by 1 cycle. Minimum 2 cycles from m_rd_en.
//  s_rd_valid in the same cycle as s_rd_en is not sampled; sampling starts the cycle after.
//  m_rd_data holds its value between responses. m_rd_valid and m_err are single-cycle pulses.
//  cnt is 8-bit and saturates; it never wraps.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//   - In RD_WAIT, cnt increments every cycle.
//   - If cnt==TIMEOUT-1 and s_rd_valid[sel]=0: next cycle m_rd_valid=1, m_err=1,
//     m_rd_data=ERR_DATA; go to IDLE.
//   - Valid in the same cycle as expiry: valid wins and returns normal data.
//   - A late s_rd_valid after a timeout, arriving in IDLE, is ignored.
//  BUS_TIMEOUT_EN undefined: no counter; RD_WAIT waits indefinitely; TIMEOUT is unused.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles, then release.
//     -> all outputs 0, m_busy=0; check the cycle after release.
//  2. Read 0x0010; slave0 returns valid with 0x12345678 one cycle later.
//     -> s_rd_en=0001 in the request cycle; m_rd_valid=1, data 0x12345678 at cycle +2; m_err=0.
//  3. Write 0x4001 with data 0xA5 and mask 0001.
//     -> s_wr_en=0100 in the same cycle, s_addr=0x4001; m_busy stays 0.
//  4. Read 0x6000 (unmapped).
//     -> next cycle m_rd_valid=1, m_err=1, m_rd_data=0xDEADBEEF; no s_rd_en asserted.
//  5. Read 0x8000; slave1 stays silent and slave3 pulses valid.
//     -> slave3 valid ignored; with BUS_TIMEOUT_EN, err response at cycle 17 (TIMEOUT=16).
//  6. Read 0x5000; assert rst_n=0 at cycle +1; slave3 valid arrives at cycle +2.
//     -> no m_rd_valid; state IDLE, m_busy=0.

Source files
------------

// File: rtl/bus_fabric.sv
// Single-master, N-slave memory-mapped fabric: base/mask decode, posted writes, one outstanding read.
// Optional read timeout is enabled with `define BUS_TIMEOUT_EN.
module bus_fabric #(
    parameter int unsigned NSLAVES = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter logic [NSLAVES*ADDR_W-1:0] SLV_BASE = {16'h5000, 16'h4000, 16'h8000, 16'h0000},
    parameter logic [NSLAVES*ADDR_W-1:0] SLV_MASK = {16'hF000, 16'hF000, 16'h8000, 16'hC000},
    parameter int unsigned TIMEOUT = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic                      m_rd_en,
    input  logic                      m_wr_en,
    input  logic [DATA_W-1:0]         m_wr_data,
    input  logic [DATA_W/8-1:0]       m_wr_mask,
    output logic [DATA_W-1:0]         m_rd_data,
    output logic                      m_rd_valid,
    output logic                      m_err,
    output logic                      m_busy,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wr_data,
    output logic [DATA_W/8-1:0]       s_wr_mask,
    output logic [NSLAVES-1:0]        s_rd_en,
    output logic [NSLAVES-1:0]        s_wr_en,
    input  logic [NSLAVES*DATA_W-1:0] s_rd_data,
    input  logic [NSLAVES-1:0]        s_rd_valid
);

    localparam int unsigned SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    if (NSLAVES == 0 || NSLAVES > 8) begin : g_chk_nslaves
        $error("bus_fabric: NSLAVES must be 1..8");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_chk_timeout
        $error("bus_fabric: TIMEOUT must be 2..255");
    end

    typedef enum logic [0:0] {StIdle, StRdWait} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               err_q, err_d;
    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_valid;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    assign s_addr     = m_addr;
    assign s_wr_data  = m_wr_data;
    assign s_wr_mask  = m_wr_mask;
    assign m_rd_data  = rd_data_q;
    assign m_rd_valid = rd_valid_q;
    assign m_err      = err_q;
    assign m_busy     = (state_q == StRdWait);
    assign sel_data   = s_rd_data[sel_q*DATA_W +: DATA_W];
    assign sel_valid  = s_rd_valid[sel_q];

    // Scan from the top so the lowest-index hit is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NSLAVES) - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        s_rd_en    = '0;
        s_wr_en    = '0;
`ifdef BUS_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (m_rd_en && m_wr_en) begin
                    err_d = 1'b1;
                end else if (m_wr_en) begin
                    if (hit) s_wr_en[hit_idx] = 1'b1;
                    else     err_d = 1'b1;
                end else if (m_rd_en) begin
                    if (hit) begin
                        s_rd_en[hit_idx] = 1'b1;
                        sel_d            = hit_idx;
                        state_d          = StRdWait;
`ifdef BUS_TIMEOUT_EN
                        cnt_d            = '0;
`endif
                    end else begin
                        rd_valid_d = 1'b1;
                        err_d      = 1'b1;
                        rd_data_d  = ERR_DATA;
                    end
                end
            end
            StRdWait: begin
`ifdef BUS_TIMEOUT_EN
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`endif
                if (sel_valid) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = sel_data;
                    state_d    = StIdle;
`ifdef BUS_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    rd_valid_d = 1'b1;
                    err_d      = 1'b1;
                    rd_data_d  = ERR_DATA;
                    state_d    = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: directed scenarios plus randomized traffic against a
// table-driven address map model.
module tb_bus_fabric;

    localparam int TO = 16;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;
    localparam logic [15:0] BASES [4] = '{16'h0000, 16'h8000, 16'h4000, 16'h5000};
    localparam logic [15:0] MASKS [4] = '{16'hC000, 16'h8000, 16'hF000, 16'hF000};
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk, rst_n;
    logic [15:0]  m_addr;
    logic         m_rd_en, m_wr_en;
    logic [31:0]  m_wr_data;
    logic [3:0]   m_wr_mask;
    logic [31:0]  m_rd_data;
    logic         m_rd_valid, m_err, m_busy;
    logic [15:0]  s_addr;
    logic [31:0]  s_wr_data;
    logic [3:0]   s_wr_mask;
    logic [3:0]   s_rd_en, s_wr_en;
    logic [127:0] s_rd_data;
    logic [3:0]   s_rd_valid;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_data;

    bus_fabric #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en),
        .m_wr_data(m_wr_data), .m_wr_mask(m_wr_mask), .m_rd_data(m_rd_data),
        .m_rd_valid(m_rd_valid), .m_err(m_err), .m_busy(m_busy), .s_addr(s_addr),
        .s_wr_data(s_wr_data), .s_wr_mask(s_wr_mask), .s_rd_en(s_rd_en), .s_wr_en(s_wr_en),
        .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic int decode(input logic [15:0] a);
        for (int i = 0; i < 4; i++) if ((a & MASKS[i]) == BASES[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int idx);
        return (idx < 0) ? 4'b0000 : 4'(1 << idx);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_chk++; if ({m_rd_valid, m_err, m_busy} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags: got %b want 000", {m_rd_valid, m_err, m_busy}); end
        n_chk++; if (m_rd_data !== 32'h0) begin n_fail++;
            $display("FAIL reset_data: got %h want 00000000", m_rd_data); end
        n_chk++; if ({s_rd_en, s_wr_en} !== 8'h00) begin n_fail++;
            $display("FAIL reset_en: got %h want 00", {s_rd_en, s_wr_en}); end
        exp_data = 32'h0;
    endtask

    task automatic test_read();
        m_addr = 16'h0010; m_rd_en = 1'b1;
        #1;
        n_chk++; if (s_rd_en !== 4'b0001) begin n_fail++;
            $display("FAIL read_req_en: got %b want 0001", s_rd_en); end
        tick();
        m_rd_en = 1'b0; s_rd_data[0 +: 32] = 32'h12345678; s_rd_valid = 4'b0001;
        n_chk++; if ({m_busy, m_rd_valid} !== 2'b10) begin n_fail++;
            $display("FAIL read_wait: got busy/valid %b want 10", {m_busy, m_rd_valid}); end
        tick();
        s_rd_valid = 4'b0000;
        n_chk++; if ({m_rd_valid, m_err, m_busy} !== 3'b100) begin n_fail++;
            $display("FAIL read_resp_flags: got %b want 100", {m_rd_valid, m_err, m_busy}); end
        n_chk++; if (m_rd_data !== 32'h12345678) begin n_fail++;
            $display("FAIL read_resp_data: got %h want 12345678", m_rd_data); end
        tick();
        n_chk++; if (m_rd_valid !== 1'b0 || m_rd_data !== 32'h12345678) begin n_fail++;
            $display("FAIL read_hold: got %b/%h want 0/12345678", m_rd_valid, m_rd_data); end
        exp_data = 32'h12345678;
    endtask

    task automatic test_write();
        m_addr = 16'h4001; m_wr_en = 1'b1; m_wr_data = 32'hA5; m_wr_mask = 4'b0001;
        #1;
        n_chk++; if (s_wr_en !== 4'b0100 || s_rd_en !== 4'b0000) begin n_fail++;
            $display("FAIL write_en: got wr %b rd %b want 0100 0000", s_wr_en, s_rd_en); end
        n_chk++; if ({s_addr, s_wr_data, s_wr_mask} !== {16'h4001, 32'hA5, 4'b0001}) begin
            n_fail++; $display("FAIL write_pass: got %h %h %b want 4001 000000a5 0001",
                               s_addr, s_wr_data, s_wr_mask); end
        tick();
        m_wr_en = 1'b0;
        n_chk++; if ({m_busy, m_err, m_rd_valid} !== 3'b000) begin n_fail++;
            $display("FAIL write_after: got %b want 000", {m_busy, m_err, m_rd_valid}); end
    endtask

    task automatic test_unmapped();
        m_addr = 16'h6000; m_rd_en = 1'b1;
        #1;
        n_chk++; if (s_rd_en !== 4'b0000) begin n_fail++;
            $display("FAIL unmap_rd_en: got %b want 0000", s_rd_en); end
        tick();
        m_rd_en = 1'b0;
        n_chk++; if ({m_rd_valid, m_err, m_busy} !== 3'b110 || m_rd_data !== ERRD) begin
            n_fail++; $display("FAIL unmap_rd_resp: got %b %h want 110 deadbeef",
                               {m_rd_valid, m_err, m_busy}, m_rd_data); end
        exp_data = ERRD;
        tick();
        n_chk++; if ({m_rd_valid, m_err} !== 2'b00) begin n_fail++;
            $display("FAIL unmap_pulse: got %b want 00", {m_rd_valid, m_err}); end
        m_wr_en = 1'b1;
        #1;
        n_chk++; if (s_wr_en !== 4'b0000) begin n_fail++;
            $display("FAIL unmap_wr_en: got %b want 0000", s_wr_en); end
        tick();
        m_wr_en = 1'b0;
        n_chk++; if ({m_rd_valid, m_err} !== 2'b01) begin n_fail++;
            $display("FAIL unmap_wr_err: got %b want 01", {m_rd_valid, m_err}); end
        m_addr = 16'h0010; m_rd_en = 1'b1; m_wr_en = 1'b1;
        #1;
        n_chk++; if ({s_rd_en, s_wr_en} !== 8'h00) begin n_fail++;
            $display("FAIL both_en: got %h want 00", {s_rd_en, s_wr_en}); end
        tick();
        m_rd_en = 1'b0; m_wr_en = 1'b0;
        n_chk++; if ({m_rd_valid, m_err, m_busy} !== 3'b010) begin n_fail++;
            $display("FAIL both_err: got %b want 010", {m_rd_valid, m_err, m_busy}); end
    endtask

    task automatic test_wrong_slave();
        m_addr = 16'h8000; m_rd_en = 1'b1;
        #1;
        n_chk++; if (s_rd_en !== 4'b0010) begin n_fail++;
            $display("FAIL wrong_req_en: got %b want 0010", s_rd_en); end
        tick();
        m_rd_en = 1'b0; s_rd_data[96 +: 32] = 32'hCAFE0003; s_rd_data[32 +: 32] = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            logic exp_v;
            s_rd_valid = (k == 2) ? 4'b1000 : 4'b0000;
            tick();
            exp_v = TO_EN && (k + 1 == TO + 1);
            n_chk++; if (m_rd_valid !== exp_v || m_err !== exp_v) begin n_fail++;
                $display("FAIL wrong_cycle%0d: got valid/err %b%b want %b%b", k + 1,
                         m_rd_valid, m_err, exp_v, exp_v); end
        end
        s_rd_valid = 4'b0000;
`ifdef BUS_TIMEOUT_EN
        exp_data = ERRD;
        s_rd_data[32 +: 32] = 32'h11112222; s_rd_valid = 4'b0010;
        tick();
        s_rd_valid = 4'b0000;
        n_chk++; if (m_rd_valid !== 1'b0 || m_rd_data !== ERRD || m_busy !== 1'b0) begin
            n_fail++; $display("FAIL late_valid: got %b %h busy %b want 0 deadbeef 0",
                               m_rd_valid, m_rd_data, m_busy); end
`else
        n_chk++; if (m_busy !== 1'b1) begin n_fail++;
            $display("FAIL wait_forever: got busy %b want 1", m_busy); end
        s_rd_data[32 +: 32] = 32'h11112222; s_rd_valid = 4'b0010;
        tick();
        s_rd_valid = 4'b0000;
        n_chk++; if ({m_rd_valid, m_err} !== 2'b10 || m_rd_data !== 32'h11112222) begin
            n_fail++; $display("FAIL slow_resp: got %b %h want 10 11112222",
                               {m_rd_valid, m_err}, m_rd_data); end
        exp_data = 32'h11112222;
`endif
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_valid_at_expiry();
        logic [31:0] want;
        want = 32'h0;
        m_addr = 16'h0010; m_rd_en = 1'b1;
        tick();
        m_rd_en = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            s_rd_data[0 +: 32] = 32'hABCD0000 + 32'(k);
            s_rd_valid = (k == TO) ? 4'b0001 : 4'b0000;
            if (k == TO) want = 32'hABCD0000 + 32'(k);
            tick();
            n_chk++; if (m_rd_valid !== (k == TO) || m_err !== 1'b0) begin n_fail++;
                $display("FAIL expiry_cycle%0d: got %b%b want %b0", k + 1, m_rd_valid,
                         m_err, (k == TO)); end
        end
        s_rd_valid = 4'b0000;
        n_chk++; if (m_rd_data !== want) begin n_fail++;
            $display("FAIL expiry_data: got %h want %h", m_rd_data, want); end
        exp_data = want;
    endtask
`endif

    task automatic test_reset_mid_read();
        m_addr = 16'h5000; m_rd_en = 1'b1;
        #1;
        n_chk++; if (s_rd_en !== 4'b1000) begin n_fail++;
            $display("FAIL rst_req_en: got %b want 1000", s_rd_en); end
        tick();
        m_rd_en = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; s_rd_data[96 +: 32] = 32'h77778888; s_rd_valid = 4'b1000;
        n_chk++; if ({m_busy, m_rd_valid} !== 2'b00 || m_rd_data !== 32'h0) begin n_fail++;
            $display("FAIL rst_mid: got %b %h want 00 00000000", {m_busy, m_rd_valid},
                     m_rd_data); end
        tick();
        s_rd_valid = 4'b0000;
        n_chk++; if ({m_rd_valid, m_err, m_busy} !== 3'b000) begin n_fail++;
            $display("FAIL rst_late: got %b want 000", {m_rd_valid, m_err, m_busy}); end
        exp_data = 32'h0;
    endtask

    task automatic test_random();
        logic [3:0] regions [8] = '{4'h0, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hC};
        for (int t = 0; t < 300; t++) begin
            int kind, idx, lat;
            logic [15:0] a;
            logic [31:0] want;
            logic [3:0] noise;
            kind = int'($urandom_range(0, 9));
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a[15:12] = regions[$urandom_range(0, 7)];
            idx = decode(a);
            m_addr = a;
            s_rd_valid = 4'($urandom);
            if (kind <= 3) begin
                m_rd_en = 1'b1;
                #1;
                n_chk++; if (s_rd_en !== onehot(idx) || s_wr_en !== 4'b0) begin n_fail++;
                    $display("FAIL rnd_rd_en[%0d]: got %b want %b", t, s_rd_en,
                             onehot(idx)); end
                tick();
                m_rd_en = 1'b0;
                if (idx < 0) begin
                    s_rd_valid = 4'b0;
                    n_chk++; if ({m_rd_valid, m_err} !== 2'b11 || m_rd_data !== ERRD) begin
                        n_fail++; $display("FAIL rnd_unmap[%0d]: got %b %h want 11 %h", t,
                                           {m_rd_valid, m_err}, m_rd_data, ERRD); end
                    exp_data = ERRD;
                end else begin
                    lat = int'($urandom_range(1, 6));
                    want = 32'h0;
                    for (int k = 1; k <= lat; k++) begin
                        n_chk++; if ({m_busy, m_rd_valid} !== 2'b10) begin n_fail++;
                            $display("FAIL rnd_wait[%0d]: got %b want 10", t,
                                     {m_busy, m_rd_valid}); end
                        for (int s = 0; s < 4; s++) s_rd_data[s*32 +: 32] = $urandom;
                        noise = 4'($urandom);
                        if (k == lat) begin
                            noise = noise | onehot(idx);
                            want = s_rd_data[idx*32 +: 32];
                        end else begin
                            noise = noise & ~onehot(idx);
                        end
                        s_rd_valid = noise;
                        m_rd_en = 1'($urandom); m_wr_en = 1'($urandom);
                        #1;
                        n_chk++; if ({s_rd_en, s_wr_en} !== 8'h00) begin n_fail++;
                            $display("FAIL rnd_busy_en[%0d]: got %h want 00", t,
                                     {s_rd_en, s_wr_en}); end
                        tick();
                        m_rd_en = 1'b0; m_wr_en = 1'b0;
                    end
                    s_rd_valid = 4'b0;
                    n_chk++; if ({m_rd_valid, m_err, m_busy} !== 3'b100 || m_rd_data !== want)
                    begin n_fail++; $display("FAIL rnd_resp[%0d]: got %b %h want 100 %h", t,
                                             {m_rd_valid, m_err, m_busy}, m_rd_data, want); end
                    exp_data = want;
                end
            end else if (kind <= 6) begin
                m_wr_en = 1'b1; m_wr_data = $urandom; m_wr_mask = 4'($urandom);
                #1;
                n_chk++; if (s_wr_en !== onehot(idx) || s_rd_en !== 4'b0) begin n_fail++;
                    $display("FAIL rnd_wr_en[%0d]: got %b want %b", t, s_wr_en,
                             onehot(idx)); end
                tick();
                m_wr_en = 1'b0; s_rd_valid = 4'b0;
                n_chk++; if ({m_rd_valid, m_err} !== {1'b0, idx < 0} || m_rd_data !== exp_data)
                begin n_fail++; $display("FAIL rnd_wr[%0d]: got %b %h want %b %h", t,
                                         {m_rd_valid, m_err}, m_rd_data, {1'b0, idx < 0},
                                         exp_data); end
            end else if (kind == 7) begin
                m_rd_en = 1'b1; m_wr_en = 1'b1;
                #1;
                n_chk++; if ({s_rd_en, s_wr_en} !== 8'h00) begin n_fail++;
                    $display("FAIL rnd_both_en[%0d]: got %h want 00", t, {s_rd_en, s_wr_en});
                end
                tick();
                m_rd_en = 1'b0; m_wr_en = 1'b0; s_rd_valid = 4'b0;
                n_chk++; if ({m_rd_valid, m_err, m_busy} !== 3'b010) begin n_fail++;
                    $display("FAIL rnd_both[%0d]: got %b want 010", t,
                             {m_rd_valid, m_err, m_busy}); end
            end else begin
                tick();
                s_rd_valid = 4'b0;
                n_chk++; if ({m_rd_valid, m_err, m_busy} !== 3'b000 || m_rd_data !== exp_data)
                begin n_fail++; $display("FAIL rnd_idle[%0d]: got %b %h want 000 %h", t,
                                         {m_rd_valid, m_err, m_busy}, m_rd_data, exp_data); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; m_addr = '0; m_rd_en = 1'b0; m_wr_en = 1'b0; m_wr_data = '0;
        m_wr_mask = '0; s_rd_data = '0; s_rd_valid = '0; exp_data = '0;
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_wrong_slave();
`ifdef BUS_TIMEOUT_EN
        test_valid_at_expiry();
`endif
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
